compare_4: RTL and testbench

Registered 4-bit unsigned magnitude comparator. Compares operands `a` and `b` each clock and drives three mutually exclusive flags: greater, lesser and equal. The flags are registered with one-cycle latency so the block drops into synchronous datapaths without adding a combinational path. An optional cascade input lets several instances chain into wider comparators.

---
 rtl/compare_4_pkg.sv | 25 ++
 rtl/compare_bit_cell.sv | 33 +++
 rtl/compare_4.sv | 74 +++++++
 tb/tb_compare_4.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/compare_4_pkg.sv
// Shared types for the compare_4 registered magnitude comparator:
// default width, the three-way result enum and its flag encoding.
package compare_4_pkg;

  localparam int CMP_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_result_t;

  // Map a three-way result onto the {gt, lt, eq} one-hot flag vector.
  function automatic logic [2:0] cmp_to_flags(input cmp_result_t res);
    logic [2:0] flags;
    flags = 3'b001;
    case (res)
      CMP_GT:  flags = 3'b100;
      CMP_LT:  flags = 3'b010;
      default: flags = 3'b001;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/compare_bit_cell.sv
// One bit of the MSB-first compare chain. Once a more significant bit has
// decided the outcome it is passed through untouched; otherwise the first
// differing bit decides it here.
import compare_4_pkg::*;

module compare_bit_cell (
  input  logic        a_i,
  input  logic        b_i,
  input  logic        decided_in,
  input  cmp_result_t result_in,
  output logic        decided_out,
  output cmp_result_t result_out
);

  // Propagate an upstream decision, or resolve on this bit if it differs.
  always_comb begin
    decided_out = decided_in;
    result_out  = result_in;
    if (!decided_in) begin
      if (a_i != b_i) begin
        decided_out = 1'b1;
        if (a_i) begin
          result_out = CMP_GT;
        end else begin
          result_out = CMP_LT;
        end
      end else begin
        result_out = CMP_EQ;
      end
    end
  end

endmodule

// File: rtl/compare_4.sv
// Registered unsigned magnitude comparator with one-cycle latency.
// Flags gt/lt/eq are one-hot out of reset and all zero during reset.
// Inputs are sampled every cycle; there is no enable and no handshake.
// Optional feature macro: COMPARE_4_CASCADE_EN adds gt_in/lt_in/eq_in so
// an equal local result is resolved by a lower-order stage.
import compare_4_pkg::*;

module compare_4 #(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARE_4_CASCADE_EN
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
`endif
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // Chain node k carries the state entering bit k-1; node WIDTH is the
  // undecided seed at the MSB, node 0 is the final local result.
  logic        decided [WIDTH:0];
  cmp_result_t result  [WIDTH:0];
  cmp_result_t final_res;

  assign decided[WIDTH] = 1'b0;
  assign result[WIDTH]  = CMP_EQ;

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
    compare_bit_cell u_cell (
      .a_i        (a[i]),
      .b_i        (b[i]),
      .decided_in (decided[i+1]),
      .result_in  (result[i+1]),
      .decided_out(decided[i]),
      .result_out (result[i])
    );
  end

  // Keep the local decision when operands differ; otherwise resolve the tie.
  always_comb begin
    final_res = result[0];
    if (!decided[0]) begin
`ifdef COMPARE_4_CASCADE_EN
      if (eq_in) begin
        final_res = CMP_EQ;
      end else if (gt_in && !lt_in) begin
        final_res = CMP_GT;
      end else if (lt_in && !gt_in) begin
        final_res = CMP_LT;
      end else begin
        final_res = CMP_EQ;
      end
`else
      final_res = CMP_EQ;
`endif
    end
  end

  // Output register: cleared by reset, otherwise captures this cycle's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      {gt, lt, eq} <= 3'b000;
    end else begin
      {gt, lt, eq} <= cmp_to_flags(final_res);
    end
  end

endmodule

// File: tb/tb_compare_4.sv
// Self-checking bench for compare_4: directed vector table, mid-stream reset,
// exhaustive sweep, randomized run against an arithmetic reference model,
// and cascade resolution when COMPARE_4_CASCADE_EN is defined.
module tb_compare_4;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       gt_in;
  logic       lt_in;
  logic       eq_in;
  logic       gt;
  logic       lt;
  logic       eq;

  int n_checks;
  int n_fail;

  logic [2:0] exp_q[$];
  string      name_q[$];

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  compare_4 #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
`ifdef COMPARE_4_CASCADE_EN
    .gt_in(gt_in),
    .lt_in(lt_in),
    .eq_in(eq_in),
`endif
    .gt   (gt),
    .lt   (lt),
    .eq   (eq)
  );

  // Reference model from the comparison rules, using integer arithmetic.
  function automatic logic [2:0] ref_flags(input logic r, input int av, input int bv,
                                           input logic [2:0] ci);
    logic [2:0] f;
    if (r) return 3'b000;
    if (av > bv)      f = 3'b100;
    else if (av < bv) f = 3'b010;
    else              f = 3'b001;
`ifdef COMPARE_4_CASCADE_EN
    // ci = {gt_in, lt_in, eq_in}
    if (av == bv) begin
      if (ci[0])                f = 3'b001;
      else if (ci == 3'b100)    f = 3'b100;
      else if (ci == 3'b010)    f = 3'b010;
      else                      f = 3'b001;
    end
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got {gt,lt,eq}=%b expected %b", name, got, expv);
    end
  endtask

  // Driver: new inputs at the falling edge; shortly after, the outputs must
  // still show the result of the previous cycle's inputs (scoreboard pop).
  task automatic step(input string name, input logic r, input logic [3:0] av,
                      input logic [3:0] bv, input logic [2:0] ci, input logic [2:0] expv);
    @(negedge clk);
    rst   = r;
    a     = av;
    b     = bv;
    gt_in = ci[2];
    lt_in = ci[1];
    eq_in = ci[0];
    #1;
    if (exp_q.size() > 0) begin
      check(name_q.pop_front(), {gt, lt, eq}, exp_q.pop_front());
    end
    exp_q.push_back(expv);
    name_q.push_back(name);
  endtask

  task automatic step_model(input string name, input logic r, input logic [3:0] av,
                            input logic [3:0] bv, input logic [2:0] ci);
    step(name, r, av, bv, ci, ref_flags(r, int'(av), int'(bv), ci));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; a = '0; b = '0; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;

    vecs.push_back('{"reset0",   1'b1, 4'd14, 4'd10, 3'b000});
    vecs.push_back('{"reset1",   1'b1, 4'd14, 4'd10, 3'b000});
    vecs.push_back('{"14v10",    1'b0, 4'd14, 4'd10, 3'b100});
    vecs.push_back('{"8v9",      1'b0, 4'd8,  4'd9,  3'b010});
    vecs.push_back('{"1v6",      1'b0, 4'd1,  4'd6,  3'b010});
    vecs.push_back('{"7v12",     1'b0, 4'd7,  4'd12, 3'b010});
    vecs.push_back('{"9v2",      1'b0, 4'd9,  4'd2,  3'b100});
    vecs.push_back('{"15v3",     1'b0, 4'd15, 4'd3,  3'b100});
    vecs.push_back('{"10v10",    1'b0, 4'd10, 4'd10, 3'b001});
    vecs.push_back('{"15v0",     1'b0, 4'd15, 4'd0,  3'b100});
    vecs.push_back('{"0v15",     1'b0, 4'd0,  4'd15, 3'b010});
    vecs.push_back('{"0v0",      1'b0, 4'd0,  4'd0,  3'b001});
    vecs.push_back('{"15v15",    1'b0, 4'd15, 4'd15, 3'b001});
    vecs.push_back('{"8v7_unsg", 1'b0, 4'd8,  4'd7,  3'b100});
    // mid-stream reset: pair on the reset edge is discarded
    vecs.push_back('{"mid_pre",  1'b0, 4'd14, 4'd10, 3'b100});
    vecs.push_back('{"mid_rst",  1'b1, 4'd3,  4'd12, 3'b000});
    vecs.push_back('{"mid_post", 1'b0, 4'd5,  4'd2,  3'b100});
    vecs.push_back('{"mid_post2",1'b0, 4'd2,  4'd5,  3'b010});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].a, vecs[i].b, 3'b001, vecs[i].exp);
    end

    // exhaustive sweep with one-hot invariant check on each cycle
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ab;
      ab = 8'(i);
      step_model("sweep", 1'b0, ab[7:4], ab[3:0], 3'b001);
      if (i > 0) check("onehot", {2'b00, ($countones({gt, lt, eq}) == 1)}, 3'b001);
    end

    // randomized stream with occasional reset
    for (int i = 0; i < 300; i++) begin
      logic r;
      logic [2:0] ci;
      r  = ($urandom_range(0, 19) == 0);
`ifdef COMPARE_4_CASCADE_EN
      ci = 3'($urandom_range(0, 7));
`else
      ci = 3'b001;
`endif
      step_model("random", r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ci);
    end

`ifdef COMPARE_4_CASCADE_EN
    step("casc_gt",    1'b0, 4'd5, 4'd5, 3'b100, 3'b100);
    step("casc_lt",    1'b0, 4'd5, 4'd5, 3'b010, 3'b010);
    step("casc_both",  1'b0, 4'd5, 4'd5, 3'b110, 3'b001);
    step("casc_none",  1'b0, 4'd5, 4'd5, 3'b000, 3'b001);
    step("casc_eqin",  1'b0, 4'd5, 4'd5, 3'b101, 3'b001);
    step("casc_local", 1'b0, 4'd6, 4'd5, 3'b010, 3'b100);
`endif

    // drain the last expectation
    step("drain", 1'b1, 4'd0, 4'd0, 3'b001, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
